// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder: operands and start in, status and result out.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  ready, busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output ready, busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, stepped LSB-first over WIDTH bits.
// Results land in sum/cout on the final bit edge and are flagged by a one-cycle done pulse.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   logic             s_bit;
   logic             carry_nxt;
   logic [WIDTH-1:0] acc_shift;

   assign s_bit     = a_q[0] ^ b_q[0] ^ carry_q;
   assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
   assign acc_shift = {s_bit, acc_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            acc_d   = acc_shift;
            carry_d = carry_nxt;
            cnt_d   = cnt_q + CntW'(1);
            // Final bit: publish the completed shift value including this edge's sum bit.
            if (cnt_q == CntW'(WIDTH - 1)) begin
               sum_d   = acc_shift;
               cout_d  = carry_nxt;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.ready = (state_q == StIdle);
   assign bus.busy  = (state_q == StRun);
   assign bus.done  = (state_q == StDone);
   assign bus.sum   = sum_q;
   assign bus.cout  = cout_q;

endmodule
